// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired control unit: widths, opcode and
// ALU codes, FSM state encoding, decode class and strobe bundles.
package control_unit_pkg;

  localparam int DATA_W   = 32;
  localparam int OPC_W    = 5;
  localparam int ALU_OP_W = 5;

  // Instruction opcodes, found in ir[31:27]
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_ANDI = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_ORI  = 5'b01110;
  localparam logic [OPC_W-1:0] OPC_IN   = 5'b10110;
  localparam logic [OPC_W-1:0] OPC_OUT  = 5'b10111;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  // ALU function selects
  localparam logic [ALU_OP_W-1:0] ALU_NONE = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'b00011;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'b00101;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'b00110;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } state_t;

  // Exactly one class bit is set for any opcode
  typedef struct packed {
    logic cls_ld;
    logic cls_ldi;
    logic cls_st;
    logic cls_alu_r;
    logic cls_alu_i;
    logic cls_in;
    logic cls_out;
    logic cls_nop;
    logic cls_halt;
    logic cls_illegal;
  } cls_t;

  // Everything the control unit drives toward the datapath
  typedef struct packed {
    logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out, ba_out;
    logic pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable;
    logic hi_enable, lo_enable, outport_enable, inport_enable, r15_enable, con_enable;
    logic pc_increment, read, ram_write, gra, grb, grc, r_in, r_out;
    logic [ALU_OP_W-1:0] alu_op;
    logic run;
    logic illegal_op;
  } strobes_t;

  // Instructions that form an address/immediate as Rb(or 0)+C in T3/T4
  function automatic logic uses_addr_path(input cls_t c);
    return c.cls_ld | c.cls_ldi | c.cls_st;
  endfunction

  // Instructions that continue into the memory steps T6/T7
  function automatic logic is_mem_op(input cls_t c);
    return c.cls_ld | c.cls_st;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Strobe bus between the control unit (master) and the datapath (slave).
interface control_unit_if;
  import control_unit_pkg::*;

  logic [DATA_W-1:0]   ir;
  logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out, ba_out;
  logic pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable;
  logic hi_enable, lo_enable, outport_enable, inport_enable, r15_enable, con_enable;
  logic pc_increment, read, ram_write, gra, grb, grc, r_in, r_out;
  logic [ALU_OP_W-1:0] alu_op;
  logic run;
  logic illegal_op;

  modport master (
    input  ir,
    output pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out, ba_out,
    output pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable,
    output hi_enable, lo_enable, outport_enable, inport_enable, r15_enable, con_enable,
    output pc_increment, read, ram_write, gra, grb, grc, r_in, r_out,
    output alu_op, run, illegal_op
  );

  modport slave (
    output ir,
    input  pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out, ba_out,
    input  pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable,
    input  hi_enable, lo_enable, outport_enable, inport_enable, r15_enable, con_enable,
    input  pc_increment, read, ram_write, gra, grb, grc, r_in, r_out,
    input  alu_op, run, illegal_op
  );

endinterface

// File: rtl/control_unit_ctrl_decode.sv
// Opcode decoder: classifies ir[31:27] and picks the ALU function for
// arithmetic instructions. Purely combinational.
module control_unit_ctrl_decode
  import control_unit_pkg::*;
(
  input  logic [DATA_W-1:0]   ir_i,
  output cls_t                cls_o,
  output logic [ALU_OP_W-1:0] alu_op_o
);

  logic [OPC_W-1:0] opc_s;
  logic             ir_unused_s;

  assign opc_s       = ir_i[DATA_W-1 -: OPC_W];
  // Register fields and constants are consumed by the datapath, not here
  assign ir_unused_s = ^ir_i[DATA_W-OPC_W-1:0];

  // Map opcode to its class and ALU function; immediates reuse reg-reg codes
  always_comb begin
    cls_o    = '0;
    alu_op_o = ALU_NONE;
    case (opc_s)
      OPC_LD:   cls_o.cls_ld  = 1'b1;
      OPC_LDI:  cls_o.cls_ldi = 1'b1;
      OPC_ST:   cls_o.cls_st  = 1'b1;
      OPC_ADD:  begin cls_o.cls_alu_r = 1'b1; alu_op_o = ALU_ADD; end
      OPC_SUB:  begin cls_o.cls_alu_r = 1'b1; alu_op_o = ALU_SUB; end
      OPC_AND:  begin cls_o.cls_alu_r = 1'b1; alu_op_o = ALU_AND; end
      OPC_OR:   begin cls_o.cls_alu_r = 1'b1; alu_op_o = ALU_OR;  end
      OPC_ADDI: begin cls_o.cls_alu_i = 1'b1; alu_op_o = ALU_ADD; end
      OPC_ANDI: begin cls_o.cls_alu_i = 1'b1; alu_op_o = ALU_AND; end
      OPC_ORI:  begin cls_o.cls_alu_i = 1'b1; alu_op_o = ALU_OR;  end
      OPC_IN:   cls_o.cls_in   = 1'b1;
      OPC_OUT:  cls_o.cls_out  = 1'b1;
      OPC_NOP:  cls_o.cls_nop  = 1'b1;
      OPC_HALT: cls_o.cls_halt = 1'b1;
      default:  cls_o.cls_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: state register plus per-state strobe decode.
// Fetch is T0..T2; execute steps start at T3 once IR holds the instruction,
// so execute-step strobes are decoded from the live IR opcode.
module control_unit
  import control_unit_pkg::*;
(
  input logic            clk,
  input logic            clr,
  control_unit_if.master bus
);

  state_t              state_q, state_d;
  cls_t                cls_s;
  logic [ALU_OP_W-1:0] dec_alu_s;
  strobes_t            strb_s;

  control_unit_ctrl_decode u_decode (
    .ir_i     (bus.ir),
    .cls_o    (cls_s),
    .alu_op_o (dec_alu_s)
  );

  // Next-state sequencing: fetch, then an instruction-length execute tail
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    state_d = ST_T1;
      ST_T1:    state_d = ST_T2;
      ST_T2:    state_d = ST_T3;
      ST_T3: begin
        if (cls_s.cls_halt) begin
          state_d = ST_HALT;
        end else if (uses_addr_path(cls_s) || cls_s.cls_alu_r || cls_s.cls_alu_i) begin
          state_d = ST_T4;
        end else begin
          state_d = ST_T0;
        end
      end
      ST_T4:    state_d = ST_T5;
      ST_T5: begin
        if (is_mem_op(cls_s)) begin
          state_d = ST_T6;
        end else begin
          state_d = ST_T0;
        end
      end
      ST_T6:    state_d = ST_T7;
      ST_T7:    state_d = ST_T0;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  // State register; clr wins at any edge, including mid-instruction
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobe decode for the current step; RESET and HALT keep everything low
  always_comb begin
    strb_s = '0;
    case (state_q)
      ST_T0: begin
        strb_s.run          = 1'b1;
        strb_s.pc_out       = 1'b1;
        strb_s.mar_enable   = 1'b1;
        strb_s.pc_increment = 1'b1;
        strb_s.z_enable     = 1'b1;
        strb_s.alu_op       = ALU_ADD;
      end
      ST_T1: begin
        strb_s.run        = 1'b1;
        strb_s.zlo_out    = 1'b1;
        strb_s.pc_enable  = 1'b1;
        strb_s.read       = 1'b1;
        strb_s.mdr_enable = 1'b1;
      end
      ST_T2: begin
        strb_s.run       = 1'b1;
        strb_s.mdr_out   = 1'b1;
        strb_s.ir_enable = 1'b1;
      end
      ST_T3: begin
        strb_s.run = 1'b1;
        if (uses_addr_path(cls_s)) begin
          // Base register goes through the R0-as-zero path
          strb_s.grb      = 1'b1;
          strb_s.ba_out   = 1'b1;
          strb_s.y_enable = 1'b1;
        end else if (cls_s.cls_alu_r || cls_s.cls_alu_i) begin
          strb_s.grb      = 1'b1;
          strb_s.r_out    = 1'b1;
          strb_s.y_enable = 1'b1;
        end else if (cls_s.cls_out) begin
          strb_s.gra            = 1'b1;
          strb_s.r_out          = 1'b1;
          strb_s.outport_enable = 1'b1;
        end else if (cls_s.cls_in) begin
          strb_s.inport_out = 1'b1;
          strb_s.gra        = 1'b1;
          strb_s.r_in       = 1'b1;
        end else begin
          // nop and halt are silent here; undefined opcodes flag for one cycle
          strb_s.illegal_op = cls_s.cls_illegal;
        end
      end
      ST_T4: begin
        strb_s.run = 1'b1;
        if (uses_addr_path(cls_s)) begin
          strb_s.c_sign_extended_out = 1'b1;
          strb_s.z_enable            = 1'b1;
          strb_s.alu_op              = ALU_ADD;
        end else if (cls_s.cls_alu_r) begin
          strb_s.grc      = 1'b1;
          strb_s.r_out    = 1'b1;
          strb_s.z_enable = 1'b1;
          strb_s.alu_op   = dec_alu_s;
        end else if (cls_s.cls_alu_i) begin
          strb_s.c_sign_extended_out = 1'b1;
          strb_s.z_enable            = 1'b1;
          strb_s.alu_op              = dec_alu_s;
        end else begin
          strb_s.z_enable = 1'b0;
        end
      end
      ST_T5: begin
        strb_s.run     = 1'b1;
        strb_s.zlo_out = 1'b1;
        if (is_mem_op(cls_s)) begin
          strb_s.mar_enable = 1'b1;
        end else begin
          strb_s.gra  = 1'b1;
          strb_s.r_in = 1'b1;
        end
      end
      ST_T6: begin
        strb_s.run        = 1'b1;
        strb_s.mdr_enable = 1'b1;
        if (cls_s.cls_st) begin
          // MDR loads from the register bus, not memory
          strb_s.gra   = 1'b1;
          strb_s.r_out = 1'b1;
        end else begin
          strb_s.read = 1'b1;
        end
      end
      ST_T7: begin
        strb_s.run = 1'b1;
        if (cls_s.cls_st) begin
          strb_s.ram_write = 1'b1;
        end else begin
          strb_s.mdr_out = 1'b1;
          strb_s.gra     = 1'b1;
          strb_s.r_in    = 1'b1;
        end
      end
      default: strb_s = '0;
    endcase
  end

  assign bus.pc_out              = strb_s.pc_out;
  assign bus.zlo_out             = strb_s.zlo_out;
  assign bus.zhi_out             = strb_s.zhi_out;
  assign bus.hi_out              = strb_s.hi_out;
  assign bus.lo_out              = strb_s.lo_out;
  assign bus.mdr_out             = strb_s.mdr_out;
  assign bus.inport_out          = strb_s.inport_out;
  assign bus.c_sign_extended_out = strb_s.c_sign_extended_out;
  assign bus.ba_out              = strb_s.ba_out;
  assign bus.pc_enable           = strb_s.pc_enable;
  assign bus.mar_enable          = strb_s.mar_enable;
  assign bus.mdr_enable          = strb_s.mdr_enable;
  assign bus.ir_enable           = strb_s.ir_enable;
  assign bus.y_enable            = strb_s.y_enable;
  assign bus.z_enable            = strb_s.z_enable;
  assign bus.hi_enable           = strb_s.hi_enable;
  assign bus.lo_enable           = strb_s.lo_enable;
  assign bus.outport_enable      = strb_s.outport_enable;
  assign bus.inport_enable       = strb_s.inport_enable;
  assign bus.r15_enable          = strb_s.r15_enable;
  assign bus.con_enable          = strb_s.con_enable;
  assign bus.pc_increment        = strb_s.pc_increment;
  assign bus.read                = strb_s.read;
  assign bus.ram_write           = strb_s.ram_write;
  assign bus.gra                 = strb_s.gra;
  assign bus.grb                 = strb_s.grb;
  assign bus.grc                 = strb_s.grc;
  assign bus.r_in                = strb_s.r_in;
  assign bus.r_out               = strb_s.r_out;
  assign bus.alu_op              = strb_s.alu_op;
  assign bus.run                 = strb_s.run;
  assign bus.illegal_op          = strb_s.illegal_op;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a step-counting instruction model predicts every
// strobe each cycle, and directed instruction sequences add literal checks.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] ir_v = 32'h0;
  always #5 clk = ~clk;

  control_unit_if cu_if ();
  assign cu_if.ir = ir_v;

  control_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (cu_if)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Strobe masks, bit i of act_v
  localparam logic [28:0] M_PC_OUT  = 29'd1 << 0;
  localparam logic [28:0] M_ZLO_OUT = 29'd1 << 1;
  localparam logic [28:0] M_MDR_OUT = 29'd1 << 5;
  localparam logic [28:0] M_IN_OUT  = 29'd1 << 6;
  localparam logic [28:0] M_CSE     = 29'd1 << 7;
  localparam logic [28:0] M_BA_OUT  = 29'd1 << 8;
  localparam logic [28:0] M_PC_EN   = 29'd1 << 9;
  localparam logic [28:0] M_MAR_EN  = 29'd1 << 10;
  localparam logic [28:0] M_MDR_EN  = 29'd1 << 11;
  localparam logic [28:0] M_IR_EN   = 29'd1 << 12;
  localparam logic [28:0] M_Y_EN    = 29'd1 << 13;
  localparam logic [28:0] M_Z_EN    = 29'd1 << 14;
  localparam logic [28:0] M_OUTP_EN = 29'd1 << 17;
  localparam logic [28:0] M_PC_INC  = 29'd1 << 21;
  localparam logic [28:0] M_READ    = 29'd1 << 22;
  localparam logic [28:0] M_RAM_WR  = 29'd1 << 23;
  localparam logic [28:0] M_GRA     = 29'd1 << 24;
  localparam logic [28:0] M_GRB     = 29'd1 << 25;
  localparam logic [28:0] M_GRC     = 29'd1 << 26;
  localparam logic [28:0] M_R_IN    = 29'd1 << 27;
  localparam logic [28:0] M_R_OUT   = 29'd1 << 28;
  localparam logic [28:0] M_BUS     = 29'h0000_01FF | M_R_OUT;

  logic [28:0] act_v;
  assign act_v = {cu_if.r_out, cu_if.r_in, cu_if.grc, cu_if.grb, cu_if.gra, cu_if.ram_write,
                  cu_if.read, cu_if.pc_increment, cu_if.con_enable, cu_if.r15_enable,
                  cu_if.inport_enable, cu_if.outport_enable, cu_if.lo_enable, cu_if.hi_enable,
                  cu_if.z_enable, cu_if.y_enable, cu_if.ir_enable, cu_if.mdr_enable,
                  cu_if.mar_enable, cu_if.pc_enable, cu_if.ba_out, cu_if.c_sign_extended_out,
                  cu_if.inport_out, cu_if.mdr_out, cu_if.lo_out, cu_if.hi_out, cu_if.zhi_out,
                  cu_if.zlo_out, cu_if.pc_out};

  // ---------------- behavioural model ----------------
  int k_m    = 0;     // step number inside the current instruction
  bit rst_m  = 1'b1;
  bit halt_m = 1'b0;

  function automatic int instr_len(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00010: return 8;
      5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b01100, 5'b01101, 5'b01110: return 6;
      default: return 4;
    endcase
  endfunction

  function automatic void expect_cycle(input int k, input logic [4:0] op,
                                       output logic [28:0] m, output logic [4:0] a,
                                       output logic run, output logic ill);
    bit addr_p, alu_r, alu_i;
    addr_p = (op == 5'b00000) || (op == 5'b00001) || (op == 5'b00010);
    alu_r  = (op >= 5'b00011) && (op <= 5'b00110);
    alu_i  = (op >= 5'b01100) && (op <= 5'b01110);
    m = '0; a = 5'd0; run = 1'b1; ill = 1'b0;
    case (k)
      0: begin m = M_PC_OUT | M_MAR_EN | M_PC_INC | M_Z_EN; a = 5'b00011; end
      1: m = M_ZLO_OUT | M_PC_EN | M_READ | M_MDR_EN;
      2: m = M_MDR_OUT | M_IR_EN;
      3: begin
        if (addr_p) m = M_GRB | M_BA_OUT | M_Y_EN;
        else if (alu_r || alu_i) m = M_GRB | M_R_OUT | M_Y_EN;
        else if (op == 5'b10111) m = M_GRA | M_R_OUT | M_OUTP_EN;
        else if (op == 5'b10110) m = M_IN_OUT | M_GRA | M_R_IN;
        else if (op != 5'b11010 && op != 5'b11011) ill = 1'b1;
      end
      4: begin
        if (addr_p) begin m = M_CSE | M_Z_EN; a = 5'b00011; end
        else if (alu_r) begin m = M_GRC | M_R_OUT | M_Z_EN; a = op; end
        else begin
          m = M_CSE | M_Z_EN;
          a = (op == 5'b01100) ? 5'b00011 : (op == 5'b01101) ? 5'b00101 : 5'b00110;
        end
      end
      5: m = addr_p && op != 5'b00001 ? (M_ZLO_OUT | M_MAR_EN) : (M_ZLO_OUT | M_GRA | M_R_IN);
      6: m = (op == 5'b00010) ? (M_GRA | M_R_OUT | M_MDR_EN) : (M_READ | M_MDR_EN);
      7: m = (op == 5'b00010) ? M_RAM_WR : (M_MDR_OUT | M_GRA | M_R_IN);
      default: m = '0;
    endcase
  endfunction

  // Model step tracking, advanced on the same edge as the DUT
  always @(posedge clk) begin
    if (clr) begin
      rst_m <= 1'b1; halt_m <= 1'b0; k_m <= 0;
    end else if (rst_m) begin
      rst_m <= 1'b0; k_m <= 0;
    end else if (halt_m) begin
      k_m <= k_m;
    end else if (k_m == 3 && ir_v[31:27] == 5'b11011) begin
      halt_m <= 1'b1;
    end else if (k_m + 1 == instr_len(ir_v[31:27])) begin
      k_m <= 0;
    end else begin
      k_m <= k_m + 1;
    end
  end

  // Every-cycle comparison against the model, plus bus-drive exclusivity
  always @(negedge clk) begin
    logic [28:0] em;
    logic [4:0]  ea;
    logic        er, ei;
    if (chk_en) begin
      if (rst_m || halt_m) begin
        em = '0; ea = 5'd0; er = 1'b0; ei = 1'b0;
      end else begin
        expect_cycle(k_m, ir_v[31:27], em, ea, er, ei);
      end
      n_vec++;
      if ({act_v, cu_if.alu_op, cu_if.run, cu_if.illegal_op} !== {em, ea, er, ei}) begin
        n_err++;
        $display("FAIL model_cycle t=%0t step=%0d ir=%h: got strobes=%h alu=%h run=%b ill=%b, want strobes=%h alu=%h run=%b ill=%b",
                 $time, k_m, ir_v, act_v, cu_if.alu_op, cu_if.run, cu_if.illegal_op, em, ea, er, ei);
      end
      n_vec++;
      if ($countones(act_v & M_BUS) > 1 || (cu_if.read && cu_if.ram_write)) begin
        n_err++;
        $display("FAIL bus_exclusive t=%0t: got strobes=%h, want at most one bus driver and no read+ram_write",
                 $time, act_v);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Start in T0, issue one instruction, count edges until the next T0
  task automatic run_instr(input logic [31:0] ir_val, input int exp_len, input string name);
    int n;
    ir_v = ir_val;
    n = 0;
    do begin
      edge1();
      n++;
    end while (!(cu_if.pc_out && cu_if.mar_enable) && n < 40);
    check(name, n, exp_len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: two edges with clr high, then release into T0
    clr = 1'b1;
    edge1();
    edge1();
    chk_en = 1'b1;
    check("reset_run", cu_if.run, 0);
    check("reset_strobes", act_v, 0);
    clr = 1'b0;
    edge1();
    check("t0_fetch", {cu_if.pc_out, cu_if.mar_enable, cu_if.pc_increment, cu_if.z_enable}, 4'b1111);
    check("t0_aluop", cu_if.alu_op, 5'b00011);

    // ldi R2,R0,0x65
    ir_v = 32'h0900_0065;
    repeat (3) edge1();
    check("ldi_t3", {cu_if.grb, cu_if.ba_out, cu_if.y_enable, cu_if.r_out}, 4'b1110);
    edge1();
    check("ldi_t4", {cu_if.c_sign_extended_out, cu_if.z_enable, cu_if.alu_op}, {2'b11, 5'b00011});
    edge1();
    check("ldi_t5", {cu_if.zlo_out, cu_if.gra, cu_if.r_in}, 3'b111);
    edge1();
    check("ldi_back_t0", cu_if.pc_out, 1);

    // st 0x87(R1)
    ir_v = 32'h1080_0087;
    repeat (6) edge1();
    check("st_t6", {cu_if.r_out, cu_if.gra, cu_if.mdr_enable, cu_if.read}, 4'b1110);
    edge1();
    check("st_t7", act_v, M_RAM_WR);
    edge1();
    check("st_back_t0", cu_if.pc_out, 1);

    // Latency table across the instruction set
    run_instr(32'hBB00_0000, 4, "lat_out");
    run_instr(32'hB300_0000, 4, "lat_in");
    run_instr(32'h1800_0000, 6, "lat_add");
    run_instr(32'h2000_0000, 6, "lat_sub");
    run_instr(32'h2800_0000, 6, "lat_and");
    run_instr(32'h3000_0000, 6, "lat_or");
    run_instr(32'h6000_0000, 6, "lat_addi");
    run_instr(32'h6800_0000, 6, "lat_andi");
    run_instr(32'h7000_0000, 6, "lat_ori");
    run_instr(32'h0000_0000, 8, "lat_ld");
    run_instr(32'h1080_0087, 8, "lat_st");
    run_instr(32'hD000_0000, 4, "lat_nop");

    // Undefined opcode 11111: one-cycle illegal_op in T3, then fetch again
    ir_v = 32'hF800_0000;
    repeat (3) edge1();
    check("illegal_t3", cu_if.illegal_op, 1);
    edge1();
    check("illegal_gone", {cu_if.illegal_op, cu_if.pc_out}, 2'b01);

    // halt: parks with run=0 until clr
    ir_v = 32'hD800_0000;
    repeat (4) edge1();
    check("halt_run", cu_if.run, 0);
    repeat (20) edge1();
    check("halt_hold", {cu_if.run, cu_if.pc_out}, 2'b00);
    clr = 1'b1;
    edge1();
    check("halt_clr_reset", cu_if.run, 0);
    clr = 1'b0;
    edge1();
    check("halt_restart_t0", cu_if.pc_out, 1);

    // clr in ld T6 aborts the instruction on that edge
    ir_v = 32'h0000_0000;
    repeat (6) edge1();
    check("ld_t6", {cu_if.read, cu_if.mdr_enable}, 2'b11);
    clr = 1'b1;
    edge1();
    check("ld_abort", {cu_if.read, cu_if.mdr_enable, cu_if.run}, 3'b000);
    clr = 1'b0;
    edge1();
    check("ld_abort_t0", cu_if.pc_out, 1);
    edge1();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
